// File: rtl/debounce_n.sv
`default_nettype none
// ============================================================================
// Module      : debounce_n
// Description : Multi-channel input conditioner. Each channel synchronizes an
//               asynchronous pin, filters it in restart or integrator mode
//               into a stable level, and produces single-cycle rise, fall and
//               long-hold event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_n #(
  parameter int WIDTH     = 4,
  parameter int N_DFF     = 2,
  parameter int MIN_TIME  = 3,
  parameter int MODE      = 0,
  parameter int LONG_TIME = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] hold
);

  // Filter counter must hold 0..MIN_TIME (integrator upper bound).
  localparam int c_cnt_w = ($clog2(MIN_TIME + 1) < 1) ? 1 : $clog2(MIN_TIME + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic [N_DFF-1:0]   sync_q;
    logic [N_DFF-1:0]   sync_d;
    logic               s;
    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;
    logic               out_q;
    logic               out_d;
    logic               rise_q;
    logic               rise_d;
    logic               fall_q;
    logic               fall_d;

    // Shift the raw pin through the synchronizer chain; stage 0 takes the pin.
    always_comb begin
      sync_d    = sync_q;
      sync_d[0] = in[gi];
      for (int k = 1; k < N_DFF; k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end

    // Only the last synchronizer stage is safe to use downstream.
    assign s = sync_q[N_DFF-1];

    if (MODE == 0) begin : g_restart
      localparam logic [c_cnt_w-1:0] c_min_last = c_cnt_w'(MIN_TIME - 1);

      // Restart filter: count consecutive disagreeing samples, any agreeing
      // sample throws the progress away.
      always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (s != out_q) begin
          if (cnt_q == c_min_last) begin
            out_d = s;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
      end
    end else begin : g_integ
      localparam logic [c_cnt_w-1:0] c_min_full = c_cnt_w'(MIN_TIME);

      // Integrator filter: saturating up/down count, output switches only at
      // the rails so glitches delay rather than restart the decision.
      always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (s) begin
          if (cnt_q != c_min_full) begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - c_cnt_one;
        end
        if (cnt_d == c_min_full) begin
          out_d = 1'b1;
        end else if (cnt_d == '0) begin
          out_d = 1'b0;
        end
      end
    end

    // Edge events are flagged on the same edge that updates the level.
    always_comb begin
      rise_d = out_d & ~out_q;
      fall_d = out_q & ~out_d;
    end

    // Channel state; reset discards all filter progress immediately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
        cnt_q  <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign out[gi]  = out_q;
    assign rise[gi] = rise_q;
    assign fall[gi] = fall_q;

    if (LONG_TIME > 0) begin : g_hold
      localparam int c_hold_w = ($clog2(LONG_TIME + 1) < 1) ? 1 : $clog2(LONG_TIME + 1);
      localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
      localparam logic [c_hold_w-1:0] c_long_last = c_hold_w'(LONG_TIME - 1);
      localparam logic [c_hold_w-1:0] c_long_full = c_hold_w'(LONG_TIME);

      logic [c_hold_w-1:0] h_q;
      logic [c_hold_w-1:0] h_d;
      logic                hold_q;
      logic                hold_d;

      // Count cycles spent high; saturation guarantees one pulse per high
      // period, and a low level clears the count.
      always_comb begin
        h_d    = '0;
        hold_d = 1'b0;
        if (out_q) begin
          h_d = h_q;
          if (h_q != c_long_full) begin
            h_d = h_q + c_hold_one;
          end
          hold_d = (h_q == c_long_last);
        end
      end

      // Hold counter and registered hold pulse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          h_q    <= '0;
          hold_q <= 1'b0;
        end else begin
          h_q    <= h_d;
          hold_q <= hold_d;
        end
      end

      assign hold[gi] = hold_q;
    end else begin : g_no_hold
      assign hold[gi] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/debounce_n.md
# debounce_n

Multi-channel, parametrised input conditioner that replaces the separate per-pin synchronizer, debounce and hysteresis blocks. Each of `WIDTH` asynchronous inputs is synchronised, filtered in a selectable mode (restart-on-glitch or up/down integrator), and qualified into a stable level with single-cycle rise, fall and long-hold event pulses. It sits directly behind board buttons and switches and feeds control logic that consumes clean levels or events.

## Interface
- `WIDTH`, 4: number of independent channels.
- `N_DFF`, 2: synchronizer depth per channel, 1 or more.
- `MIN_TIME`, 3: filter length in clock cycles, 1 or more.
- `MODE`, 0: 0 = restart (any sample equal to `out` clears progress); 1 = integrator (saturating up/down count).
- `LONG_TIME`, 0: cycles `out` must stay high before `hold` fires; 0 disables `hold`.
- `clk` input 1: single system clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in` input WIDTH: raw asynchronous pins.
- `out` output WIDTH: debounced level per channel.
- `rise` output WIDTH: one-cycle pulse when `out[i]` goes 0->1.
- `fall` output WIDTH: one-cycle pulse when `out[i]` goes 1->0.
- `hold` output WIDTH: one-cycle pulse after `out[i]` has been high `LONG_TIME` cycles.

## Operation
- Channels fully independent. Identical logic replicated per bit.
- Sync: `N_DFF`-stage flop chain; last stage is `s[i]`. Only `s[i]` is used downstream.
- Counter widths: `$clog2(MIN_TIME+1)` for the filter and `$clog2(LONG_TIME+1)` for hold (minimum 1 bit each).
- MODE 0, counter `c` in 0..MIN_TIME-1, evaluated each edge:
  - `s == out`: `c <= 0`.
  - `s != out` and `c == MIN_TIME-1`: `out <= s`, `c <= 0`.
  - `s != out` otherwise: `c <= c+1`.
  - Result: `out` follows `s` only after `MIN_TIME` consecutive differing samples. A single agreeing sample restarts the count.
- MODE 1, accumulator `a` in 0..MIN_TIME, evaluated each edge:
  - `s == 1`: `a` increments, saturating at `MIN_TIME`.
  - `s == 0`: `a` decrements, saturating at 0.
  - `out <= 1` when next `a == MIN_TIME`; `out <= 0` when next `a == 0`; otherwise `out` holds. Glitches only delay the output, they do not reset progress.
- `rise`/`fall` are registered on the same edge that changes `out`: high for exactly that one cycle, never both high together.
- Hold counter `h` (only when `LONG_TIME > 0`):
  - Clears while `out == 0`.
  - Increments while `out == 1`, saturating at `LONG_TIME`.
  - `hold` pulses on the edge where `h` reaches `LONG_TIME`. At most once per high period.
- `LONG_TIME == 0`: `hold` tied 0 and no hold counter is implemented.
- `MIN_TIME == 1`: `out` equals `s` delayed one cycle in both modes.

## Timing
- Reset (`rst_n` low, async): sync chain, `c`, `a`, `h`, `out`, `rise`, `fall` and `hold` all cleared to 0 immediately, without waiting for a clock edge. Release is synchronous to the next `clk` edge.
- Reset mid-filter discards all progress. A pin held high through reset needs the full latency again after release.
- Latency from a clean pin step to the `out` change: `N_DFF + MIN_TIME` rising edges, in both modes, starting from a settled state.
- `hold` rises `LONG_TIME` cycles after `rise`.
- A fall before `LONG_TIME` suppresses `hold` for that high period.

## Test plan
- Defaults (MODE 0), `in[0]` 0->1 held steady → `out[0]` rises 5 edges after the pin change; `rise[0]` high exactly 1 cycle; other channels stay 0.
- MODE 0, MIN_TIME=3, `in[1]` high 2 cycles, low 1 cycle, high 2 cycles → `out[1]` stays 0, no `rise`. Then hold high 3+ cycles → `out[1]` = 1.
- MODE 1, MIN_TIME=5, `in[2]` pattern 1,1,1,0,1,1,1 → `a` reaches 5 on the 7th sample; `out[2]` rises there (restart mode would still be 0).
- LONG_TIME=10, `in[3]` held high 30 cycles → one `hold[3]` pulse 10 cycles after `rise[3]`. Then a release at 6 cycles high → no `hold`, one `fall`.
- Assert `rst_n` low mid-count with `in` all high → all outputs 0 immediately. After release, `out` all 1 after `N_DFF+MIN_TIME` edges with simultaneous `rise` on all bits.
- Inputs toggling every cycle for 100 cycles, MODE 0, MIN_TIME=3 → `out` never changes; `rise`, `fall` and `hold` remain 0.
